// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings and the per-stage control record for pipe_controller.
// When PIPE_CTRL_ILLEGAL_EN is defined, the record carries an illegal-instruction mark.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int unsigned ALU_CODE_W = 4;

    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'h2;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'h3;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'h5;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'h6;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'h7;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'h8;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'h9;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2
    } src_a_e;

    typedef struct packed {
        logic                  reg_write;
        result_src_e           result_src;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  jalr;
        logic [ALU_CODE_W-1:0] alu_ctrl;
        src_a_e                alu_src_a;
        logic                  alu_src_b;
        logic [2:0]            funct3;
`ifdef PIPE_CTRL_ILLEGAL_EN
        logic                  illegal;
`endif
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_controller_branch_cond.sv
// pipe_controller_branch_cond: branch-taken decision from funct3 and the ALU flags of a-b.
// Carry is the carry-out of a-b, so carry = 1 means no borrow (a >= b unsigned).
module pipe_controller_branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       neg,
    input  logic       ovf,
    input  logic       carry,
    output logic       take_c
);

    // Evaluate the six RV32I branch conditions; 010/011 never take.
    always_comb begin
        take_c = 1'b0;
        case (funct3)
            3'b000:  take_c = zero;
            3'b001:  take_c = ~zero;
            3'b100:  take_c = neg ^ ovf;
            3'b101:  take_c = ~(neg ^ ovf);
            3'b110:  take_c = ~carry;
            3'b111:  take_c = carry;
            default: take_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: RV32I five-stage pipeline control unit (decode in D, stage copies E/M/W).
// Build macro PIPE_CTRL_ILLEGAL_EN adds illegal-instruction tracking (IllegalW, IllegalSeen).
module pipe_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned           ALUCTRL_W = 4,
    parameter logic [ALU_CODE_W-1:0] ENC_ADD   = 4'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 FlushE,
    input  logic                 StallE,
    input  logic                 ZeroE,
    input  logic                 NegE,
    input  logic                 OvfE,
    input  logic                 CarryE,
    output logic [2:0]           ImmSrcD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [1:0]           ALUSrcAE,
    output logic                 ALUSrcBE,
    output logic                 PCSrcE,
    output logic                 PCTgtSrcE,
    output logic                 ResultSrcE0,
    output logic                 MemWriteM,
    output logic [2:0]           Funct3M,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
`ifdef PIPE_CTRL_ILLEGAL_EN
    output logic                 IllegalW,
    output logic                 IllegalSeen,
`endif
    output logic [1:0]           ResultSrcW
);

    // ALU operation from funct3; sub only for R-type, sra for R/I-type with bit 30.
    function automatic logic [ALU_CODE_W-1:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                                      input logic is_r);
        logic [ALU_CODE_W-1:0] code;
        code = ENC_ADD;
        case (f3)
            3'b000:  code = (is_r && f7b5) ? ALU_SUB : ENC_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // Main decoder: opcode to control record; unknown opcodes become a NOP.
    function automatic ctrl_t main_dec(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic f7b5);
        ctrl_t c;
        c          = CTRL_NOP;
        c.funct3   = f3;
        c.alu_ctrl = ENC_ADD;
        case (opc)
            OP_R: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = alu_dec(f3, f7b5, 1'b1);
            end
            OP_I: begin
                c.reg_write = 1'b1;
                c.alu_src_b = 1'b1;
                c.alu_ctrl  = alu_dec(f3, f7b5, 1'b0);
            end
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_MEM;
                c.alu_src_b  = 1'b1;
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src_b = 1'b1;
            end
            OP_BRANCH: begin
                c.branch   = 1'b1;
                c.alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_PC4;
                c.jump       = 1'b1;
            end
            OP_JALR: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_PC4;
                c.jump       = 1'b1;
                c.jalr       = 1'b1;
                c.alu_src_b  = 1'b1;
            end
            OP_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src_a = SRCA_ZERO;
                c.alu_src_b = 1'b1;
            end
            OP_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = 1'b1;
            end
            default: begin
                c = CTRL_NOP;
`ifdef PIPE_CTRL_ILLEGAL_EN
                c.illegal = 1'b1;
`endif
            end
        endcase
`ifdef PIPE_CTRL_ILLEGAL_EN
        // Bit 30 is only meaningful on add/sub and srl/sra.
        if (opc == OP_R && f7b5 && f3 != 3'b000 && f3 != 3'b101) begin
            c         = CTRL_NOP;
            c.illegal = 1'b1;
        end
`endif
        return c;
    endfunction

    // Immediate format selected by opcode.
    function automatic imm_src_e imm_dec(input logic [6:0] opc);
        imm_src_e s;
        s = IMM_I;
        case (opc)
            OP_STORE:         s = IMM_S;
            OP_BRANCH:        s = IMM_B;
            OP_JAL:           s = IMM_J;
            OP_LUI, OP_AUIPC: s = IMM_U;
            default:          s = IMM_I;
        endcase
        return s;
    endfunction

    ctrl_t ctrl_dec;
    ctrl_t e_d, e_q, m_d, m_q, w_d, w_q;
    logic  take_c;

    // Stage register next-state: flush beats stall; a stalled E sends a bubble to M so
    // the held instruction reaches M exactly once.
    always_comb begin
        ctrl_dec = main_dec(op, funct3, funct7b5);
        e_d      = e_q;
        if (FlushE) begin
            e_d = CTRL_NOP;
        end else if (!StallE) begin
            e_d = ctrl_dec;
        end
        m_d = (StallE && !FlushE) ? CTRL_NOP : e_q;
        w_d = m_q;
    end

    // E/M/W control registers, cleared to a bubble on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= CTRL_NOP;
            m_q <= CTRL_NOP;
            w_q <= CTRL_NOP;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    pipe_controller_branch_cond u_branch_cond (
        .funct3 (e_q.funct3),
        .zero   (ZeroE),
        .neg    (NegE),
        .ovf    (OvfE),
        .carry  (CarryE),
        .take_c (take_c)
    );

`ifdef PIPE_CTRL_ILLEGAL_EN
    logic seen_d, seen_q;

    // Sticky record that an illegal instruction reached writeback.
    always_comb begin
        seen_d = seen_q | w_q.illegal;
    end

    // Sticky flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign IllegalW    = w_q.illegal;
    assign IllegalSeen = seen_q;
`endif

    assign ImmSrcD     = 3'(imm_dec(op));
    assign ALUControlE = ALUCTRL_W'(e_q.alu_ctrl);
    assign ALUSrcAE    = e_q.alu_src_a;
    assign ALUSrcBE    = e_q.alu_src_b;
    assign PCSrcE      = (e_q.branch & take_c) | e_q.jump;
    assign PCTgtSrcE   = e_q.jalr;
    assign ResultSrcE0 = e_q.result_src[0];
    assign MemWriteM   = m_q.mem_write;
    assign Funct3M     = m_q.funct3;
    assign RegWriteM   = m_q.reg_write;
    assign RegWriteW   = w_q.reg_write;
    assign ResultSrcW  = w_q.result_src;

    // Later stages only expose a subset of the record.
    logic unused_stage_bits;
    assign unused_stage_bits = ^{e_q, m_q, w_q};

endmodule
